// File: rtl/stack_disp_pkg.sv
// Shared types and helpers for the stack display sequencer.
// Contents: FSM state enum, nibble width, leading-zero blank mask helper.
package stack_disp_pkg;

    localparam int unsigned NIB_W         = 4;
    // Widest entry the blank-mask helper handles; callers zero-extend narrower data.
    localparam int unsigned LZ_MAX_W      = 64;
    localparam int unsigned LZ_MAX_DIGITS = LZ_MAX_W / NIB_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Blank every digit above the most significant nonzero nibble; digit 0 is never blanked.
    // Zero-extended upper nibbles come back blanked and are truncated away by the caller.
    function automatic logic [LZ_MAX_DIGITS-1:0] lead_zero_mask(input logic [LZ_MAX_W-1:0] data);
        logic [LZ_MAX_DIGITS-1:0] mask;
        logic                     seen;
        mask = '0;
        seen = 1'b0;
        for (int i = LZ_MAX_DIGITS - 1; i > 0; i--) begin
            if (data[i*NIB_W +: NIB_W] != '0) begin
                seen = 1'b1;
            end
            mask[i] = ~seen;
        end
        return mask;
    endfunction

endpackage

// File: rtl/stack_display_sequencer_dwell_timer.sv
// Dwell timer: loadable down-counter that saturates at zero.
// Ports: clk, rst (async, active-high), load (load counter with load_val),
//        load_val (start count), expired (registered, high while the count is zero).
module dwell_timer #(
    parameter  int unsigned DWELL = 50_000_000,
    localparam int unsigned CNT_W = $clog2(DWELL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q;

    // Load wins; otherwise count down and hold at zero so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == '0);
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/stack_display_sequencer.sv
// Stack display sequencer: walks stack entries top to bottom through a req/ack read
// port, holding each on the 7-segment digits for DWELL cycles.
// Ports: clk, rst (async, active-high), start, depth -> walk control;
//        rd_req/rd_addr/rd_ack/rd_data -> stack read port;
//        digits/blank/index -> decoder outputs; busy, done -> status. All outputs registered.
// Build option: define STACK_DISPLAY_LZ_BLANK_EN to blank leading-zero digits.
module stack_display_sequencer
    import stack_disp_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NUM_DIGITS = DATA_W / 4,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DWELL      = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W:0]             depth,
    output logic                        rd_req,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic                        rd_ack,
    input  logic [DATA_W-1:0]           rd_data,
    output logic [NUM_DIGITS*NIB_W-1:0] digits,
    output logic [NUM_DIGITS-1:0]       blank,
    output logic [ADDR_W-1:0]           index,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned       CNT_W     = $clog2(DWELL + 1);
    localparam logic [ADDR_W:0]   MAX_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             cnt_q, cnt_d;
    logic                          rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]             rd_addr_q, rd_addr_d;
    logic [NUM_DIGITS*NIB_W-1:0]   digits_q, digits_d;
    logic [NUM_DIGITS-1:0]         blank_q, blank_d;
    logic [ADDR_W-1:0]             index_q, index_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [ADDR_W:0]               depth_clamped;
    logic                          tmr_load;
    logic                          tmr_expired;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (CNT_W'(DWELL - 1)),
        .expired  (tmr_expired)
    );

    assign depth_clamped = (depth > MAX_DEPTH) ? MAX_DEPTH : depth;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        digits_d  = digits_q;
        blank_d   = blank_q;
        index_d   = index_q;
        tmr_load  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (depth == '0) begin
                        state_d = DONE;
                        blank_d = '1;
                    end else begin
                        state_d = FETCH;
                        cnt_d   = ADDR_W'(depth_clamped - 1'b1);
                    end
                end
            end
            FETCH: begin
                if (rd_ack && rd_req_q) begin
                    digits_d = rd_data;
                    index_d  = cnt_q;
`ifdef STACK_DISPLAY_LZ_BLANK_EN
                    blank_d  = NUM_DIGITS'(lead_zero_mask(LZ_MAX_W'(rd_data)));
`else
                    blank_d  = '0;
`endif
                    tmr_load = 1'b1;
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                if (tmr_expired) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q - ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address follows the entry counter only when a request is (re)issued,
        // so it stays put for the whole request.
        rd_req_d = (state_d == FETCH);
        if (state_d == FETCH) begin
            rd_addr_d = cnt_d;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            digits_q  <= '0;
            blank_q   <= '1;
            index_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            index_q   <= index_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_req  = rd_req_q;
    assign rd_addr = rd_addr_q;
    assign digits  = digits_q;
    assign blank   = blank_q;
    assign index   = index_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_stack_display_sequencer.sv
// Self-checking bench for stack_display_sequencer: a scoreboard queue of expected
// (address, data) entries is filled at each start and drained as the DUT fetches.
module tb_stack_display_sequencer;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned NUM_DIGITS = DATA_W / 4;
    localparam int unsigned DWELL      = 4;
    localparam int unsigned DEPTH_MAX  = 2 ** ADDR_W;
`ifdef STACK_DISPLAY_LZ_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [ADDR_W:0]         depth;
    logic                    rd_req;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    rd_ack;
    logic [DATA_W-1:0]       rd_data;
    logic [DATA_W-1:0]       digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic [ADDR_W-1:0]       index;
    logic                    busy;
    logic                    done;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] mem[DEPTH_MAX];
    int                n_checks = 0;
    int                n_pass   = 0;

    always #5 clk = ~clk;

    stack_display_sequencer #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS),
        .ADDR_W     (ADDR_W),
        .DWELL      (DWELL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .depth   (depth),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .digits  (digits),
        .blank   (blank),
        .index   (index),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected blank vector: a digit above 0 is blank when everything from it upward is zero.
    function automatic logic [NUM_DIGITS-1:0] exp_blank(input logic [DATA_W-1:0] d);
        logic [NUM_DIGITS-1:0] b;
        b = '0;
        for (int i = 1; i < int'(NUM_DIGITS); i++) begin
            b[i] = ((d >> (4 * i)) == '0);
        end
        return LZ_EN ? b : '0;
    endfunction

    // Pulse start for one cycle and queue the entries the walk should visit.
    task automatic do_start(input logic [ADDR_W:0] d);
        int eff;
        eff = (int'(d) > int'(DEPTH_MAX)) ? int'(DEPTH_MAX) : int'(d);
        for (int k = eff - 1; k >= 0; k--) begin
            exp_q.push_back('{addr: ADDR_W'(k), data: mem[k]});
        end
        start = 1'b1;
        depth = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Act as the stack memory for a whole walk and check every displayed entry.
    task automatic serve_walk(input int ack_dly, input bit inject);
        exp_t e;
        int   cyc;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            cyc = 0;
            while (rd_req !== 1'b1 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            chk("rd_req_rise", 32'(rd_req), 32'd1);
            chk("rd_addr", 32'(rd_addr), 32'(e.addr));
            for (int s = 0; s < ack_dly; s++) begin
                @(negedge clk);
                chk("stall_req", 32'(rd_req), 32'd1);
                chk("stall_addr", 32'(rd_addr), 32'(e.addr));
            end
            rd_ack  = 1'b1;
            rd_data = mem[rd_addr];
            @(negedge clk);
            rd_ack  = 1'b0;
            rd_data = '0;
            chk("digits", 32'(digits), 32'(e.data));
            chk("index", 32'(index), 32'(e.addr));
            chk("blank", 32'(blank), 32'(exp_blank(e.data)));
            chk("req_drop", 32'(rd_req), 32'd0);
            cyc = 0;
            while (rd_req === 1'b0 && done === 1'b0 && cyc < 100) begin
                start = (inject && e.addr == ADDR_W'(1) && cyc == 1);
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            chk("dwell_len", 32'(cyc), 32'(DWELL));
            chk("digits_held", 32'(digits), 32'(e.data));
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       seen_req;
        logic       seen_busy;
        rst     = 1'b1;
        start   = 1'b0;
        depth   = '0;
        rd_ack  = 1'b0;
        rd_data = '0;
        mem[0]  = 16'h1234;
        mem[1]  = 16'hABCD;
        mem[2]  = 16'h0007;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_blank", 32'(blank), 32'hF);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Normal walk, ack two cycles after request
        do_start(5'd3);
        chk("busy_walk", 32'(busy), 32'd1);
        serve_walk(2, 1'b0);

        // Empty stack
        do_start(5'd0);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_req", 32'(rd_req), 32'd0);
        chk("empty_blank", 32'(blank), 32'hF);
        @(negedge clk);
        chk("empty_done_clear", 32'(done), 32'd0);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_blank_hold", 32'(blank), 32'hF);

        // Start while busy is ignored
        do_start(5'd3);
        serve_walk(0, 1'b1);
        seen_req  = 1'b0;
        seen_busy = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen_req  = seen_req | rd_req;
            seen_busy = seen_busy | busy;
        end
        chk("no_extra_req", 32'(seen_req), 32'd0);
        chk("no_extra_busy", 32'(seen_busy), 32'd0);

        // Stalled acknowledge, including an all-zero entry
        mem[1] = 16'h0000;
        do_start(5'd2);
        serve_walk(20, 1'b0);

        // Spurious ack while idle
        rd_ack  = 1'b1;
        rd_data = 16'hFFFF;
        repeat (3) @(negedge clk);
        rd_ack  = 1'b0;
        rd_data = '0;
        chk("spur_digits", 32'(digits), 32'h1234);
        chk("spur_index", 32'(index), 32'd0);
        chk("spur_blank", 32'(blank), 32'(exp_blank(16'h1234)));
        chk("spur_req", 32'(rd_req), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_done", 32'(done), 32'd0);

        // Depth above maximum is clamped
        for (int k = 0; k < int'(DEPTH_MAX); k++) begin
            mem[k] = DATA_W'(k + 1) << (4 * (k % 4));
        end
        do_start(5'd20);
        serve_walk(0, 1'b0);

        // Asynchronous reset mid-fetch
        do_start(5'd2);
        chk("pre_rst_req", 32'(rd_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_rd_req", 32'(rd_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_digits", 32'(digits), 32'd0);
        chk("arst_blank", 32'(blank), 32'hF);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req", 32'(rd_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
